mem_b_read_engine: RTL

- Consumer end of the B-matrix address FIFO; pops the word addresses that the B address generator pushes in.
- Issues one memory read per address on a valid/ready request channel and captures the in-order read responses.
- Presents the returned B data words to the compute array on a valid/ready stream.
- Bounds in-flight reads with a credit counter, so the response buffer can never overflow.

---
 rtl/mm_pkg.sv | 14 +
 rtl/mem_b_read_engine_if.sv | 45 ++++
 rtl/mm_sync_fifo.sv | 47 ++++
 rtl/mem_b_read_engine.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply memory engines.
// Holds the request FSM state encoding and the default bus widths.
// No ports; imported by the B read engine and its interface users.
package mm_pkg;

  localparam int MEM_DATA_WIDTH_BYTES = 32;
  localparam int ADDR_WIDTH           = 16;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_REQ  = 1'b1
  } req_state_e;

endpackage

// File: rtl/mem_b_read_engine_if.sv
// Signal bundle between the B read engine and its neighbours.
// Groups the address FIFO head, memory request, memory response and
// downstream data stream plus status. master = engine side, slave = environment.
interface mem_b_read_engine_if #(
  parameter int ADDR_WIDTH = mm_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mm_pkg::MEM_DATA_WIDTH_BYTES * 8
);

  logic [ADDR_WIDTH-1:0] addr_fifo_data;
  logic                  addr_fifo_empty;
  logic                  addr_fifo_pop;
  logic                  mem_req_valid;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_ready;
  logic                  busy;
  logic                  err_o;

  modport master (
    input  addr_fifo_data, addr_fifo_empty,
    output addr_fifo_pop,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output data_valid, data_out,
    input  data_ready,
    output busy, err_o
  );

  modport slave (
    output addr_fifo_data, addr_fifo_empty,
    input  addr_fifo_pop,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  data_valid, data_out,
    output data_ready,
    input  busy, err_o
  );

endinterface

// File: rtl/mm_sync_fifo.sv
// Synchronous show-ahead FIFO; rd_data is the head whenever !empty.
// Ports: clk/reset_n, wr_en/wr_data (ignored when full), rd_en (ignored when
// empty), rd_data, full, empty. DEPTH must be a power of two, >= 2.
module mm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit separates the full and empty cases.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mem_b_read_engine.sv
// B-matrix read engine: pops word addresses, issues one memory read each,
// buffers the in-order responses and streams them to the compute array.
// Ports: clk, reset_n (async, active-low), bus (master side of the bundle).
module mem_b_read_engine #(
  parameter int MEM_DATA_WIDTH_BYTES = mm_pkg::MEM_DATA_WIDTH_BYTES,
  parameter int MAX_OUTSTANDING      = 4,
  parameter int ADDR_WIDTH           = mm_pkg::ADDR_WIDTH
) (
  input logic                 clk,
  input logic                 reset_n,
  mem_b_read_engine_if.master bus
);

  import mm_pkg::*;

  localparam int DW = MEM_DATA_WIDTH_BYTES * 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

  req_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         credit_q;
  logic [CW-1:0]         inflight_q;
  logic                  err_q;

  logic          can_pop;
  logic          pop;
  logic          req_fire;
  logic          consume;
  logic          rsp_ok;
  logic          rsp_stray;
  logic [DW-1:0] buf_head;
  logic          buf_full;
  logic          buf_empty;

  // A credit is held from the pop until the word leaves downstream, so the
  // buffer never has to absorb more than MAX_OUTSTANDING responses. The
  // request slot may refill in the same cycle it is accepted.
  assign can_pop   = !bus.addr_fifo_empty && (credit_q < CRED_MAX) &&
                     (state_q == R_IDLE || bus.mem_req_ready);
  // Gated with reset so the pop output is low while reset is held.
  assign pop       = can_pop && reset_n;
  assign req_fire  = (state_q == R_REQ) && bus.mem_req_ready;
  assign consume   = !buf_empty && bus.data_ready;
  assign rsp_ok    = bus.mem_rsp_valid && (inflight_q != '0);
  assign rsp_stray = bus.mem_rsp_valid && (inflight_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      R_IDLE: begin
        if (pop) begin
          addr_d  = bus.addr_fifo_data;
          state_d = R_REQ;
        end
      end
      R_REQ: begin
        if (bus.mem_req_ready) begin
          if (pop) addr_d = bus.addr_fifo_data;
          else     state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= R_IDLE;
      addr_q     <= '0;
      credit_q   <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      case ({pop, consume})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
      case ({req_fire, rsp_ok})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
      if (rsp_stray) err_q <= 1'b1;
    end
  end

  mm_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (rsp_ok),
    .wr_data (bus.mem_rsp_data),
    .rd_en   (consume),
    .rd_data (buf_head),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign bus.addr_fifo_pop = pop;
  assign bus.mem_req_valid = (state_q == R_REQ);
  assign bus.mem_req_addr  = addr_q;
  assign bus.data_valid    = !buf_empty;
  // Unwritten storage is never shown: the output reads zero when empty.
  assign bus.data_out      = buf_empty ? '0 : buf_head;
  assign bus.busy          = (credit_q != '0);
  assign bus.err_o         = err_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(buf_full && rsp_ok));
  a_credit_cap: assert property (@(posedge clk) disable iff (!reset_n)
    credit_q <= CRED_MAX);
  a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.mem_req_valid && !bus.mem_req_ready) |=> $stable(bus.mem_req_addr));
`endif

endmodule
